// File: rtl/muldiv_seq.sv
// muldiv_seq - iterative MIPS32 multiply/divide unit with the HI/LO registers.
//
// MULT/MULTU use shift-add, DIV/DIVU use restoring division. Both run on one
// shared (WIDTH+1)-bit add/sub datapath, one iteration per clock. Operands are
// reduced to magnitudes on accept; the sign is restored in the FIX state.
//
// Ports
//   clk_i     rising-edge clock
//   reset_i   synchronous, active-high, highest priority
//   start_i   request a new operation (accepted only in IDLE)
//   op_i      00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start_i)
//   a_i       rs operand: multiplicand / dividend
//   b_i       rt operand: multiplier / divisor
//   flush_i   abort an in-flight operation
//   hi_we_i   MTHI write strobe (ignored while busy)
//   lo_we_i   MTLO write strobe (ignored while busy)
//   wdata_i   MTHI/MTLO data
//   hi_o      HI register (product upper half / remainder)
//   lo_o      LO register (product lower half / quotient)
//   busy_o    stall request, high in CALC and FIX
//   done_o    one-cycle pulse when HI/LO have just been updated
module muldiv_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             flush_i,
   input  logic             hi_we_i,
   input  logic             lo_we_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             busy_o,
   output logic             done_o
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX,
      S_DONE
   } state_t;

   state_t            state_q;
   logic [CW-1:0]     cnt_q;
   logic [WIDTH-1:0]  hi_q, lo_q;
   logic              busy_q, done_q;

   // Operation context captured on accept.
   logic              is_div_q;   // op[1]
   logic              is_sgn_q;   // MULT or DIV
   logic              sa_q, sb_q; // original operand signs
   logic [WIDTH-1:0]  opnd_q;     // |multiplicand| or |divisor|

   // Working accumulator, 2*WIDTH+1 bits.
   //   multiply: acc[2W:W] partial product, acc[W-1:0] multiplier shifting out
   //   divide:   acc[2W-1:W] remainder, acc[W-1:0] dividend shifting out /
   //             quotient shifting in; acc[2W] stays zero
   logic [2*WIDTH:0]  acc_q;

   // ------------------------------------------------------------------
   // Operand magnitudes for accept. Only the signed ops (op[0]==0) take
   // |x|; the most negative value maps onto itself, which is the correct
   // unsigned magnitude.
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] abs_a, abs_b;

   always_comb begin
      abs_a = a_i;
      abs_b = b_i;
      if (!op_i[0] && a_i[WIDTH-1]) abs_a = -a_i;
      if (!op_i[0] && b_i[WIDTH-1]) abs_b = -b_i;
   end

   // ------------------------------------------------------------------
   // Shared add/sub and one iteration step.
   // ------------------------------------------------------------------
   logic [WIDTH:0]   cand;     // divide: {rem, next dividend bit}
   logic [WIDTH:0]   add_a, add_b, add_res;
   logic [WIDTH:0]   mul_sum;
   logic [2*WIDTH:0] acc_step;

   always_comb begin
      cand    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      add_a   = is_div_q ? cand : acc_q[2*WIDTH:WIDTH];
      add_b   = {1'b0, opnd_q};
      add_res = is_div_q ? (add_a - add_b) : (add_a + add_b);
      mul_sum = acc_q[0] ? add_res : acc_q[2*WIDTH:WIDTH];

      if (is_div_q) begin
         // The remainder is always below the divisor, so the shifted
         // candidate is below 2*divisor and the trial result's top bit
         // is a reliable borrow flag.
         if (!add_res[WIDTH])
            acc_step = {1'b0, add_res[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
         else
            acc_step = {1'b0, cand[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end else begin
         acc_step = {1'b0, mul_sum, acc_q[WIDTH-1:1]};
      end
   end

   // ------------------------------------------------------------------
   // Sign correction evaluated in FIX.
   // ------------------------------------------------------------------
   logic                 neg_res;
   logic [2*WIDTH-1:0]   prod, prod_fix;
   logic [WIDTH-1:0]     quo, rem;
   logic [WIDTH-1:0]     fix_hi, fix_lo;

   always_comb begin
      neg_res  = is_sgn_q & (sa_q ^ sb_q);
      prod     = acc_q[2*WIDTH-1:0];
      prod_fix = neg_res ? -prod : prod;
      quo      = acc_q[WIDTH-1:0];
      rem      = acc_q[2*WIDTH-1:WIDTH];

      if (is_div_q) begin
         // Remainder follows the dividend sign. For a zero divisor the
         // remainder holds |a|, so this also returns the original a.
         fix_hi = (is_sgn_q && sa_q) ? -rem : rem;
         if (opnd_q == '0)
            fix_lo = '1;
         else
            fix_lo = neg_res ? -quo : quo;
      end else begin
         fix_hi = prod_fix[2*WIDTH-1:WIDTH];
         fix_lo = prod_fix[WIDTH-1:0];
      end
   end

   // ------------------------------------------------------------------
   // Control FSM, HI/LO and registered status outputs.
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         is_div_q <= 1'b0;
         is_sgn_q <= 1'b0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         opnd_q   <= '0;
         acc_q    <= '0;
      end else begin
         done_q <= 1'b0;

         // MTHI/MTLO land whenever no operation is in flight, including
         // the cycle a new start is accepted (FIX overwrites them later).
         if (!busy_q) begin
            if (hi_we_i) hi_q <= wdata_i;
            if (lo_we_i) lo_q <= wdata_i;
         end

         case (state_q)
            S_IDLE: begin
               // flush beats a simultaneous start
               if (start_i && !flush_i) begin
                  is_div_q <= op_i[1];
                  is_sgn_q <= ~op_i[0];
                  sa_q     <= a_i[WIDTH-1];
                  sb_q     <= b_i[WIDTH-1];
                  opnd_q   <= op_i[1] ? abs_b : abs_a;
                  acc_q    <= {{(WIDTH+1){1'b0}}, (op_i[1] ? abs_a : abs_b)};
                  cnt_q    <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= S_CALC;
               end
            end

            S_CALC: begin
               if (flush_i) begin
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  acc_q <= acc_step;
                  if (cnt_q == LAST) begin
                     cnt_q   <= '0;
                     state_q <= S_FIX;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
            end

            S_FIX: begin
               busy_q <= 1'b0;
               if (flush_i) begin
                  state_q <= S_IDLE;
               end else begin
                  hi_q    <= fix_hi;
                  lo_q    <= fix_lo;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end

            S_DONE: begin
               // start here is deliberately dropped; no queueing
               state_q <= S_IDLE;
            end

            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign hi_o   = hi_q;
   assign lo_o   = lo_q;
   assign busy_o = busy_q;
   assign done_o = done_q;

endmodule
